// File: rtl/button_enable_gen_pkg.sv
// rtl/button_enable_gen_pkg.sv - shared front-panel state encoding and helpers
package button_enable_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_PRESS_DB   = 2'd1,
        ST_HELD       = 2'd2,
        ST_RELEASE_DB = 2'd3
    } btn_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser with synchronous reset to 0
module sync_2ff (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    // Two back-to-back flops give the asynchronous input time to settle.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_enable_gen.sv
// rtl/button_enable_gen.sv - debounced push-button to single-cycle enable pulses
module button_enable_gen
    import button_enable_gen_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_in,
    input  logic repeat_en,
    output logic enable_out,
    output logic btn_level
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RPT_MAX = max_int(REPEAT_DELAY, REPEAT_PERIOD);
    localparam int RPT_W   = $clog2(RPT_MAX + 1);

    localparam logic [DB_W-1:0]  DB_TARGET = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
    localparam logic [RPT_W-1:0] RPT_SAT   = RPT_W'(RPT_MAX);

    btn_state_t       state;
    logic             btn_s;
    logic [DB_W-1:0]  db_cnt;
    logic [RPT_W-1:0] rpt_cnt;
    logic             first_done;
    logic [31:0]      rpt_thr;
    logic             rpt_hit;

    sync_2ff u_sync (
        .clock (clock),
        .reset (reset),
        .d     (btn_in),
        .q     (btn_s)
    );

    // Repeat threshold: initial delay until the first repeat, then the period.
    // A pulse in the previous cycle blocks a hit so pulses never touch.
    always_comb begin
        rpt_thr = first_done ? 32'(REPEAT_PERIOD) : 32'(REPEAT_DELAY);
        rpt_hit = !enable_out && ((32'(rpt_cnt) + 32'd1) >= rpt_thr);
    end

    // Debounce/repeat FSM with both timers and the registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            db_cnt     <= '0;
            rpt_cnt    <= '0;
            first_done <= 1'b0;
            enable_out <= 1'b0;
            btn_level  <= 1'b0;
        end else begin
            enable_out <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (btn_s) begin
                        state  <= ST_PRESS_DB;
                        db_cnt <= DB_ONE;
                    end
                end
                ST_PRESS_DB: begin
                    if (!btn_s) begin
                        state <= ST_IDLE;
                    end else if (db_cnt == DB_TARGET) begin
                        state      <= ST_HELD;
                        enable_out <= 1'b1;
                        btn_level  <= 1'b1;
                        rpt_cnt    <= '0;
                        first_done <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                ST_HELD: begin
                    if (!btn_s) begin
                        state  <= ST_RELEASE_DB;
                        db_cnt <= DB_ONE;
                    end else if (!repeat_en) begin
                        rpt_cnt    <= '0;
                        first_done <= 1'b0;
                    end else if (rpt_hit) begin
                        enable_out <= 1'b1;
                        rpt_cnt    <= '0;
                        first_done <= 1'b1;
                    end else if (rpt_cnt != RPT_SAT) begin
                        rpt_cnt <= rpt_cnt + RPT_W'(1);
                    end
                end
                ST_RELEASE_DB: begin
                    if (btn_s) begin
                        state <= ST_HELD;
                    end else if (db_cnt == DB_TARGET) begin
                        state     <= ST_IDLE;
                        btn_level <= 1'b0;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_enable_gen.sv
// tb/tb_button_enable_gen.sv - directed bench for button_enable_gen driving a 4-bit counter
module tb_button_enable_gen;

    logic       clock;
    logic       reset;
    logic       btn_in;
    logic       repeat_en;
    logic       enable_out;
    logic       btn_level;
    logic [3:0] counter_out;

    int tests;
    int failed;

    typedef struct {
        string       name;
        logic        pre_reset;
        logic        repeat_en;
        int          len;
        logic [63:0] btn_pat;
        logic [63:0] exp_pulse;
        logic [63:0] exp_level;
        logic [3:0]  exp_count;
    } vec_t;

    vec_t vecs[4];

    button_enable_gen #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .btn_in     (btn_in),
        .repeat_en  (repeat_en),
        .enable_out (enable_out),
        .btn_level  (btn_level)
    );

    // Stand-in for first_counter: 4-bit wrapping count of enable pulses.
    always_ff @(posedge clock) begin
        if (reset) counter_out <= 4'd0;
        else if (enable_out) counter_out <= counter_out + 4'd1;
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] r;
        r = '0;
        for (int i = lo; i <= hi; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] bit_at(input int n);
        logic [63:0] r;
        r = '0;
        r[n] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic press(input int high, input int low);
        btn_in = 1'b1;
        repeat (high) step();
        btn_in = 1'b0;
        repeat (low) step();
    endtask

    initial begin
        tests     = 0;
        failed    = 0;
        reset     = 1'b1;
        btn_in    = 1'b0;
        repeat_en = 1'b0;

        // Edge index i is the edge that samples btn_pat[i]; expected bits are outputs after edge i.
        vecs[0] = '{"clean", 1'b0, 1'b0, 40, rng(0, 19),
                    bit_at(6), rng(6, 25), 4'd1};
        vecs[1] = '{"bounce", 1'b0, 1'b0, 40, rng(0, 19) & ~bit_at(1) & ~bit_at(3),
                    bit_at(10), rng(10, 25), 4'd2};
        vecs[2] = '{"glitch", 1'b0, 1'b0, 40, rng(0, 19) & ~bit_at(12) & ~bit_at(13),
                    bit_at(6), rng(6, 25), 4'd3};
        vecs[3] = '{"repeat", 1'b1, 1'b1, 45, rng(0, 27),
                    bit_at(6) | bit_at(16) | bit_at(19) | bit_at(22) | bit_at(25) | bit_at(28),
                    rng(6, 33), 4'd6};

        // Reset state held for three cycles.
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("reset_en[%0d]", i), 32'(enable_out), 32'd0);
            chk($sformatf("reset_lvl[%0d]", i), 32'(btn_level), 32'd0);
            chk($sformatf("reset_cnt[%0d]", i), 32'(counter_out), 32'd0);
        end
        reset = 1'b0;
        repeat (4) step();

        for (int v = 0; v < 4; v++) begin
            if (vecs[v].pre_reset) begin
                reset = 1'b1;
                repeat (2) step();
                reset = 1'b0;
                repeat (2) step();
            end
            repeat_en = vecs[v].repeat_en;
            for (int i = 0; i < vecs[v].len; i++) begin
                btn_in = vecs[v].btn_pat[i];
                step();
                chk($sformatf("%s_en[%0d]", vecs[v].name, i), 32'(enable_out), 32'(vecs[v].exp_pulse[i]));
                chk($sformatf("%s_lvl[%0d]", vecs[v].name, i), 32'(btn_level), 32'(vecs[v].exp_level[i]));
            end
            chk($sformatf("%s_count", vecs[v].name), 32'(counter_out), 32'(vecs[v].exp_count));
        end

        // Reset in HELD with the button still down, then re-debounce after release of reset.
        repeat_en = 1'b0;
        btn_in    = 1'b1;
        for (int i = 0; i < 21; i++) begin
            reset = (i >= 9 && i <= 11);
            step();
            if (i < 9) begin
                chk($sformatf("rst_held_en[%0d]", i), 32'(enable_out), 32'(i == 6));
                chk($sformatf("rst_held_lvl[%0d]", i), 32'(btn_level), 32'(i >= 6));
            end else if (i <= 11) begin
                chk($sformatf("rst_held_en[%0d]", i), 32'(enable_out), 32'd0);
                chk($sformatf("rst_held_lvl[%0d]", i), 32'(btn_level), 32'd0);
                chk($sformatf("rst_held_cnt[%0d]", i), 32'(counter_out), 32'd0);
            end else begin
                chk($sformatf("rst_held_en[%0d]", i), 32'(enable_out), 32'(i == 18));
                chk($sformatf("rst_held_lvl[%0d]", i), 32'(btn_level), 32'(i >= 18));
            end
        end
        reset  = 1'b0;
        btn_in = 1'b0;
        repeat (12) step();
        chk("after_reset_press_cnt", 32'(counter_out), 32'd1);

        // Fourteen more presses bring the counter to 15, the sixteenth pulse wraps it.
        for (int p = 0; p < 14; p++) press(10, 12);
        chk("count_15", 32'(counter_out), 32'd15);
        press(10, 12);
        chk("count_wrap", 32'(counter_out), 32'd0);
        chk("idle_lvl", 32'(btn_level), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
